// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers; MTHI/MTLO write directly.
// Latency: mul/div results land DATA_WIDTH+1 edges after the start edge; MTHI/MTLO land at the next edge.
// Backpressure: o_StallD holds HI/LO readers and further mul/div ops in decode while o_Busy is high.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_StartE,
    input  logic [2:0]            i_OpE,
    input  logic [DATA_WIDTH-1:0] i_SrcAE,
    input  logic [DATA_WIDTH-1:0] i_SrcBE,
    input  logic                  i_ReadHiLoD,
    input  logic                  i_MulDivD,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_StallD,
    output logic [DATA_WIDTH-1:0] o_HI,
    output logic [DATA_WIDTH-1:0] o_LO
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] CntInit = W'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t       state;
    logic [W-1:0] cnt;
    // accHi: upper product half / partial remainder; accLo: multiplier then low product, or dividend then quotient
    logic [W-1:0] accHi;
    logic [W-1:0] accLo;
    logic [W-1:0] opB;
    logic [W-1:0] srcAOrig;
    logic         isDiv;
    logic         negQ;
    logic         negR;
    logic         divZero;

    logic         signedOp;
    logic [W-1:0] absA;
    logic [W-1:0] absB;
    logic [W-1:0] mulAddend;
    logic [W:0]   mulSum;
    logic [W:0]   divShift;
    logic [W:0]   divDiff;
    logic [2*W-1:0] product;
    logic [2*W-1:0] productFix;
    logic [W-1:0] quotFix;
    logic [W-1:0] remFix;

    // Operand magnitudes, one shift-add / restoring-subtract step, and final sign correction
    always_comb begin
        signedOp   = (i_OpE == 3'd0) || (i_OpE == 3'd2);
        absA       = (signedOp && i_SrcAE[W-1]) ? -i_SrcAE : i_SrcAE;
        absB       = (signedOp && i_SrcBE[W-1]) ? -i_SrcBE : i_SrcBE;
        mulAddend  = accLo[0] ? opB : '0;
        mulSum     = {1'b0, accHi} + {1'b0, mulAddend};
        divShift   = {accHi, accLo[W-1]};
        divDiff    = divShift - {1'b0, opB};
        product    = {accHi, accLo};
        productFix = negQ ? -product : product;
        quotFix    = negQ ? -accLo : accLo;
        remFix     = negR ? -accHi : accHi;
    end

    // Decode-stage hazard: only readers of HI/LO and further mul/div ops must wait
    assign o_StallD = o_Busy & (i_ReadHiLoD | i_MulDivD);

    // Control FSM plus datapath registers; HI/LO change only on MT ops in IDLE or in FIX
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state    <= IDLE;
            cnt      <= '0;
            accHi    <= '0;
            accLo    <= '0;
            opB      <= '0;
            srcAOrig <= '0;
            isDiv    <= 1'b0;
            negQ     <= 1'b0;
            negR     <= 1'b0;
            divZero  <= 1'b0;
            o_Busy   <= 1'b0;
            o_Done   <= 1'b0;
            o_HI     <= '0;
            o_LO     <= '0;
        end else begin
            o_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_StartE) begin
                        if (i_OpE <= 3'd3) begin
                            state    <= CALC;
                            o_Busy   <= 1'b1;
                            cnt      <= CntInit;
                            isDiv    <= i_OpE[1];
                            negQ     <= signedOp & (i_SrcAE[W-1] ^ i_SrcBE[W-1]);
                            negR     <= signedOp & i_SrcAE[W-1];
                            divZero  <= i_OpE[1] && (i_SrcBE == '0);
                            srcAOrig <= i_SrcAE;
                            accHi    <= '0;
                            accLo    <= absA;
                            opB      <= absB;
                        end else if (i_OpE == 3'd4) begin
                            o_HI <= i_SrcAE;
                        end else if (i_OpE == 3'd5) begin
                            o_LO <= i_SrcAE;
                        end
                    end
                end
                CALC: begin
                    if (isDiv) begin
                        // Restored remainder is below the divisor, so dropping divShift's top bit is lossless
                        if (divDiff[W]) begin
                            accHi <= divShift[W-1:0];
                            accLo <= {accLo[W-2:0], 1'b0};
                        end else begin
                            accHi <= divDiff[W-1:0];
                            accLo <= {accLo[W-2:0], 1'b1};
                        end
                    end else begin
                        accHi <= mulSum[W:1];
                        accLo <= {mulSum[0], accLo[W-1:1]};
                    end
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - W'(1);
                    end
                end
                FIX: begin
                    if (isDiv) begin
                        if (divZero) begin
                            o_LO <= '1;
                            o_HI <= srcAOrig;
                        end else begin
                            o_LO <= quotFix;
                            o_HI <= remFix;
                        end
                    end else begin
                        o_HI <= productFix[2*W-1:W];
                        o_LO <= productFix[W-1:0];
                    end
                    state  <= IDLE;
                    o_Busy <= 1'b0;
                    o_Done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
